// File: rtl/interp_filter_sched.sv
// interp_filter_sched: feeds an 8-sample window to a shared A/B/C interpolation datapath.
// Define INTERP_ROUND_CLIP_EN to round, shift by 6 and clip captured results to 0..255.
module interp_filter_sched #(
    parameter int ROW_LEN = 64,
    parameter int DW      = 8,
    parameter int RW      = 40
) (
    input  logic            clock,
    input  logic            reset_L,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    input  logic            in_row_st,
    output logic            in_ready,
    output logic [8*DW-1:0] win_data,
    output logic [1:0]      filt_sel,
    input  logic [RW-1:0]   filt_value,
    output logic            out_valid,
    output logic [RW-1:0]   out_data,
    output logic [1:0]      out_sel,
    output logic            out_last,
    input  logic            out_ready,
    output logic            busy
);
    typedef enum logic [1:0] {FILL, ISS_A, ISS_B, ISS_C} state_t;

    localparam logic [15:0] ROW_END = 16'(ROW_LEN);

    state_t              state;
    logic [7:0][DW-1:0]  win;
    logic [3:0]          fill_cnt;
    logic [15:0]         row_cnt;
    logic                new_row;
    logic [3:0]          fill_nxt;
    logic                cap_en;
    logic [RW-1:0]       cap_val;

    assign in_ready = (state == FILL);
    assign busy     = (state != FILL) || out_valid;
    assign win_data = win;
    assign cap_en   = !out_valid || out_ready;

    // A full row without an explicit row start begins the next row implicitly
    assign new_row  = in_row_st || (row_cnt == ROW_END);
    assign fill_nxt = new_row ? 4'd1 :
                      (fill_cnt == 4'd8) ? 4'd8 : fill_cnt + 4'd1;

`ifdef INTERP_ROUND_CLIP_EN
    logic signed [RW:0] rnd;
    logic signed [RW:0] shf;

    assign rnd = $signed({filt_value[RW-1], filt_value} + (RW+1)'(32));
    assign shf = rnd >>> 6;

    always_comb begin
        if (shf[RW])
            cap_val = '0;
        else if (|shf[RW-1:8])
            cap_val = RW'(255);
        else
            cap_val = {{(RW-8){1'b0}}, shf[7:0]};
    end
`else
    assign cap_val = filt_value;
`endif

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= FILL;
            filt_sel  <= 2'd3;
            win       <= '0;
            fill_cnt  <= 4'd0;
            row_cnt   <= 16'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            out_last  <= 1'b0;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        win      <= {win[6:0], in_data};
                        fill_cnt <= fill_nxt;
                        row_cnt  <= new_row ? 16'd1 : row_cnt + 16'd1;
                        if (fill_nxt == 4'd8) begin
                            state    <= ISS_A;
                            filt_sel <= 2'd0;
                        end
                    end
                end
                ISS_A, ISS_B, ISS_C: begin
                    if (cap_en) begin
                        out_valid <= 1'b1;
                        out_data  <= cap_val;
                        out_sel   <= filt_sel;
                        out_last  <= (state == ISS_C) && (row_cnt == ROW_END);
                        unique case (state)
                            ISS_A: begin
                                state    <= ISS_B;
                                filt_sel <= 2'd1;
                            end
                            ISS_B: begin
                                state    <= ISS_C;
                                filt_sel <= 2'd2;
                            end
                            default: begin
                                state    <= FILL;
                                filt_sel <= 2'd3;
                                if (row_cnt == ROW_END) begin
                                    fill_cnt <= 4'd0;
                                    row_cnt  <= 16'd0;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    a_hold: assert property (@(posedge clock) disable iff (!reset_L)
        out_valid && !out_ready |=>
        $stable(out_data) && $stable(out_sel) && $stable(out_last));

    a_sel: assert property (@(posedge clock) disable iff (!reset_L)
        state != FILL |-> filt_sel != 2'd3);

endmodule
